// File: rtl/dnn_arith_pkg.sv
// Shared arithmetic definitions for the DNN datapath blocks.
// Divider FSM encoding and signed saturation limits.
package dnn_arith_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_NORM = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        NORM = ST_NORM,
        ITER = ST_ITER,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } div_state_e;

    function automatic logic [63:0] sat_max(input int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract |b|.
// The top remainder bit folds into the compare so the step stays exact.
module div_restore_step #(
    parameter int N = 16
) (
    input  logic [N:0]   rem_i,
    input  logic [N-1:0] div_i,
    input  logic         bit_i,
    output logic [N:0]   rem_o,
    output logic         q_o
);

    logic [N:0] shifted;
    logic [N:0] div_ext;

    assign shifted = {rem_i[N-1:0], bit_i};
    assign div_ext = {1'b0, div_i};
    assign q_o     = rem_i[N] | (shifted >= div_ext);
    assign rem_o   = q_o ? (shifted - div_ext) : shifted;

endmodule

// File: rtl/div_piped_seq.sv
// Sequential signed fixed-point divider, one quotient bit per cycle.
// Valid/ready on both sides; a single operation in flight.
module div_piped_seq
    import dnn_arith_pkg::*;
#(
    parameter int N    = 16,
    parameter int FRAC = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y_out,
    output logic [N-1:0] rem_out,
    output logic         div_zero
);

    localparam int W  = N + FRAC;
    localparam int CW = $clog2(W + 1);

    localparam logic [63:0]  MAX64 = sat_max(N);
    localparam logic [63:0]  MIN64 = sat_min(N);
    localparam logic [N-1:0] Y_MAX = MAX64[N-1:0];
    localparam logic [N-1:0] Y_MIN = MIN64[N-1:0];
    localparam logic [W-1:0] LIM_P = MAX64[W-1:0];
    localparam logic [W-1:0] LIM_N = MIN64[W-1:0];

    div_state_e state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  bmag_q, bmag_d;
    logic [W-1:0]  dq_q, dq_d;
    logic [N:0]    rem_q, rem_d;
    logic          neg_q, neg_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  r_q, r_d;
    logic          z_q, z_d;

    logic [N-1:0] amag;
    logic [N-1:0] bmag;
    logic [N-1:0] rmag;
    logic [N:0]   step_rem;
    logic         step_q;

    assign amag = a_q[N-1] ? -a_q : a_q;
    assign bmag = b_q[N-1] ? -b_q : b_q;
    assign rmag = rem_q[N-1:0];

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    div_restore_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .div_i (bmag_q),
        .bit_i (dq_q[W-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bmag_d  = bmag_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        y_d     = y_q;
        r_d     = r_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = NORM;
                end
            end
            NORM: begin
                dq_d    = W'(amag) << FRAC;
                bmag_d  = bmag;
                neg_d   = a_q[N-1] ^ b_q[N-1];
                rem_d   = '0;
                cnt_d   = CW'(W - 1);
                dz_d    = (b_q == '0);
                state_d = (b_q == '0) ? FIX : ITER;
            end
            ITER: begin
                rem_d = step_rem;
                dq_d  = {dq_q[W-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (dz_q) begin
                    y_d = a_q[N-1] ? Y_MIN : Y_MAX;
                    r_d = a_q;
                    z_d = 1'b1;
                end else begin
                    if (neg_q) begin
                        y_d = (dq_q > LIM_N) ? Y_MIN : -dq_q[N-1:0];
                    end else begin
                        y_d = (dq_q > LIM_P) ? Y_MAX : dq_q[N-1:0];
                    end
                    r_d = a_q[N-1] ? -rmag : rmag;
                    z_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bmag_q  <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            y_q     <= '0;
            r_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bmag_q  <= bmag_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            y_q     <= y_d;
            r_q     <= r_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y_out     = y_q;
    assign rem_out   = r_q;
    assign div_zero  = z_q;

endmodule

// File: tb/tb_div_piped_seq.sv
// Directed and random checks for div_piped_seq (Q16.0 and Q8.8 instances).
// Expected values come from hand tables and an integer reference model.
module tb_div_piped_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y_out;
    logic [15:0] rem_out;
    logic        div_zero;

    logic        f_in_valid = 1'b0;
    logic        f_in_ready;
    logic [15:0] f_a_in = '0;
    logic [15:0] f_b_in = '0;
    logic        f_out_valid;
    logic        f_out_ready = 1'b0;
    logic [15:0] f_y_out;
    logic [15:0] f_rem_out;
    logic        f_div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_piped_seq #(.N(16), .FRAC(0)) u0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .rem_out   (rem_out),
        .div_zero  (div_zero)
    );

    div_piped_seq #(.N(16), .FRAC(8)) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .a_in      (f_a_in),
        .b_in      (f_b_in),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .y_out     (f_y_out),
        .rem_out   (f_rem_out),
        .div_zero  (f_div_zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [15:0] r;
        logic        z;
        int          lat;
    } vec_t;

    // Start an op on u0 at a negedge and stop at the negedge where out_valid is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL timeout a=%h b=%h: out_valid=%b required 1", a, b, out_valid);
            errors++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] y, output logic [15:0] r,
                                  output logic z);
        int sa;
        int sb;
        int q;
        int rr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            z = 1'b1;
            y = (sa < 0) ? 16'h8000 : 16'h7FFF;
            r = a;
        end else begin
            q = sa / sb;
            rr = sa % sb;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            z = 1'b0;
            y = q[15:0];
            r = rr[15:0];
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (y_out !== 16'h0) begin
            $display("FAIL reset_y: got %h required 0000", y_out);
            errors++;
        end
        if (rem_out !== 16'h0) begin
            $display("FAIL reset_rem: got %h required 0000", rem_out);
            errors++;
        end
        if (out_valid !== 1'b0 || div_zero !== 1'b0) begin
            $display("FAIL reset_flags: out_valid=%b div_zero=%b required 0 0", out_valid, div_zero);
            errors++;
        end
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b required 1", in_ready);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t v[8];
        int lat;
        v[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18};
        v[1] = '{16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 18};
        v[2] = '{16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0, 18};
        v[3] = '{16'd5, 16'd0, 16'h7FFF, 16'd5, 1'b1, 2};
        v[4] = '{16'hFFFB, 16'd0, 16'h8000, 16'hFFFB, 1'b1, 2};
        v[5] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0, 1'b0, 18};
        v[6] = '{16'h8000, 16'd1, 16'h8000, 16'h0, 1'b0, 18};
        v[7] = '{16'd0, 16'hFFFD, 16'h0, 16'h0, 1'b0, 18};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].a, v[i].b, lat);
            checks += 4;
            if (y_out !== v[i].y) begin
                $display("FAIL dir%0d_y: got %h required %h", i, y_out, v[i].y);
                errors++;
            end
            if (rem_out !== v[i].r) begin
                $display("FAIL dir%0d_rem: got %h required %h", i, rem_out, v[i].r);
                errors++;
            end
            if (div_zero !== v[i].z) begin
                $display("FAIL dir%0d_dz: got %b required %b", i, div_zero, v[i].z);
                errors++;
            end
            if (lat != v[i].lat) begin
                $display("FAIL dir%0d_lat: got %0d required %0d", i, lat, v[i].lat);
                errors++;
            end
            release_out();
        end
    endtask

    task automatic test_frac();
        vec_t v[2];
        int lat;
        v[0] = '{16'h0180, 16'h0080, 16'h0300, 16'h0, 1'b0, 26};
        v[1] = '{16'h7F00, 16'h0040, 16'h7FFF, 16'h0, 1'b0, 26};
        for (int i = 0; i < 2; i++) begin
            f_in_valid = 1'b1;
            f_a_in = v[i].a;
            f_b_in = v[i].b;
            @(negedge clk);
            f_in_valid = 1'b0;
            lat = 0;
            while (!f_out_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            checks += 3;
            if (f_y_out !== v[i].y) begin
                $display("FAIL frac%0d_y: got %h required %h", i, f_y_out, v[i].y);
                errors++;
            end
            if (f_rem_out !== v[i].r || f_div_zero !== v[i].z) begin
                $display("FAIL frac%0d_rem: got %h/%b required %h/%b",
                         i, f_rem_out, f_div_zero, v[i].r, v[i].z);
                errors++;
            end
            if (lat != v[i].lat) begin
                $display("FAIL frac%0d_lat: got %0d required %0d", i, lat, v[i].lat);
                errors++;
            end
            f_out_ready = 1'b1;
            @(negedge clk);
            f_out_ready = 1'b0;
        end
    endtask

    task automatic test_handshake();
        int lat;
        run_op(16'd100, 16'd7, lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a_in = 16'd9;
            b_in = 16'd3;
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin
                $display("FAIL stall%0d_valid: got %b required 1", k, out_valid);
                errors++;
            end
            if (y_out !== 16'd14 || rem_out !== 16'd2) begin
                $display("FAIL stall%0d_data: got %h/%h required 000e/0002", k, y_out, rem_out);
                errors++;
            end
            if (in_ready !== 1'b0) begin
                $display("FAIL stall%0d_ready: got %b required 0", k, in_ready);
                errors++;
            end
        end
        in_valid = 1'b0;
        release_out();
        checks += 2;
        if (out_valid !== 1'b0) begin
            $display("FAIL accept_valid: got %b required 0", out_valid);
            errors++;
        end
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_ready: got %b required 1", in_ready);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        in_valid = 1'b1;
        a_in = 16'd1000;
        b_in = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (y_out !== 16'h0 || rem_out !== 16'h0) begin
            $display("FAIL midrst_data: got %h/%h required 0000/0000", y_out, rem_out);
            errors++;
        end
        if (out_valid !== 1'b0 || div_zero !== 1'b0) begin
            $display("FAIL midrst_flags: got %b/%b required 0/0", out_valid, div_zero);
            errors++;
        end
        if (in_ready !== 1'b1) begin
            $display("FAIL midrst_ready: got %b required 1", in_ready);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd9, 16'd3, lat);
        checks++;
        if (y_out !== 16'd3 || rem_out !== 16'd0 || lat != 18) begin
            $display("FAIL midrst_next: got y=%h rem=%h lat=%0d required 0003 0000 18",
                     y_out, rem_out, lat);
            errors++;
        end
        release_out();
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ey;
        logic [15:0] er;
        logic        ez;
        int          lat;
        int          sel;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 16'h0;
            if (sel == 1) a = 16'h8000;
            if (sel == 2) b = ($urandom_range(0, 1) == 0) ? 16'h0001 : 16'hFFFF;
            if (sel >= 3 && sel <= 5) b = 16'($signed(8'($urandom)));
            model(a, b, ey, er, ez);
            run_op(a, b, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks += 3;
            if (y_out !== ey) begin
                $display("FAIL rnd%0d_y a=%h b=%h: got %h required %h", i, a, b, y_out, ey);
                errors++;
            end
            if (rem_out !== er) begin
                $display("FAIL rnd%0d_rem a=%h b=%h: got %h required %h", i, a, b, rem_out, er);
                errors++;
            end
            if (div_zero !== ez) begin
                $display("FAIL rnd%0d_dz a=%h b=%h: got %b required %b", i, a, b, div_zero, ez);
                errors++;
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_frac();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
